// File: rtl/knap_pkg.sv
// Shared types and default sizes for the knapsack exhaustive-search sequencer.
package knap_pkg;

    localparam int KNAP_N_ITEMS = 17;
    localparam int KNAP_VAL_W   = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } knap_state_e;

endpackage

// File: rtl/knap_best_track.sv
// Stage register for the checker verdict plus best-valid-selection tracking.
module knap_best_track #(
    parameter int N_ITEMS = knap_pkg::KNAP_N_ITEMS,
    parameter int VAL_W   = knap_pkg::KNAP_VAL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_cap_en,
    input  logic               i_upd_en,
    input  logic [N_ITEMS-1:0] i_cand,
    input  logic               i_valid,
    input  logic [VAL_W-1:0]   i_value,
    output logic               o_stage_valid,
    output logic               o_found,
    output logic [N_ITEMS-1:0] o_best_sel,
    output logic [VAL_W-1:0]   o_best_value
);

    logic               r_stage_valid;
    logic [N_ITEMS-1:0] r_stage_sel;
    logic [VAL_W-1:0]   r_stage_value;
    logic               r_found;
    logic [N_ITEMS-1:0] r_best_sel;
    logic [VAL_W-1:0]   r_best_value;
    logic               w_better;

    // Strict compare keeps the earliest (lowest-index) selection on ties.
    assign w_better = r_stage_valid && (!r_found || (r_stage_value > r_best_value));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage_valid <= 1'b0;
            r_stage_sel   <= '0;
            r_stage_value <= '0;
        end else if (i_clear) begin
            r_stage_valid <= 1'b0;
            r_stage_sel   <= '0;
            r_stage_value <= '0;
        end else if (i_cap_en) begin
            r_stage_valid <= i_valid;
            r_stage_sel   <= i_cand;
            r_stage_value <= i_value;
        end else begin
            r_stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_found      <= 1'b0;
            r_best_sel   <= '0;
            r_best_value <= '0;
        end else if (i_clear) begin
            r_found      <= 1'b0;
            r_best_sel   <= '0;
            r_best_value <= '0;
        end else if (i_upd_en && w_better) begin
            r_found      <= 1'b1;
            r_best_sel   <= r_stage_sel;
            r_best_value <= r_stage_value;
        end
    end

    assign o_stage_valid = r_stage_valid;
    assign o_found       = r_found;
    assign o_best_sel    = r_best_sel;
    assign o_best_value  = r_best_value;

endmodule

// File: rtl/knap_search_ctrl.sv
// Exhaustive-search sequencer driving a combinational knapsack checker.
// Optional KNAP_STATS_EN adds n_valid, a saturating count of staged valid candidates.
module knap_search_ctrl #(
    parameter int N_ITEMS = knap_pkg::KNAP_N_ITEMS,
    parameter int VAL_W   = knap_pkg::KNAP_VAL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               first_hit,
    input  logic               abort,
    output logic [N_ITEMS-1:0] cand,
    input  logic               chk_valid,
    input  logic [VAL_W-1:0]   chk_value,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [N_ITEMS-1:0] best_sel,
    output logic [VAL_W-1:0]   best_value
`ifdef KNAP_STATS_EN
    ,
    output logic [N_ITEMS:0]   n_valid
`endif
);

    import knap_pkg::*;

    knap_state_e        r_state;
    knap_state_e        w_state_nxt;
    logic [N_ITEMS-1:0] r_cnt;
    logic               r_first;
    logic               w_start_ok;
    logic               w_last;
    logic               w_cap_en;
    logic               w_upd_en;
    logic               w_stage_valid;

    assign w_start_ok = (r_state == IDLE) && start && !abort;
    assign w_last     = (r_cnt == {N_ITEMS{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = RUN;
            RUN: begin
                if (abort)                          w_state_nxt = IDLE;
                else if (r_first && w_stage_valid)  w_state_nxt = DONE;
                else if (w_last)                    w_state_nxt = DRAIN;
            end
            DRAIN:   w_state_nxt = abort ? IDLE : DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cand     = '0;
        busy     = 1'b0;
        done     = 1'b0;
        w_cap_en = 1'b0;
        w_upd_en = 1'b0;
        case (r_state)
            RUN: begin
                cand     = r_cnt;
                busy     = 1'b1;
                w_cap_en = 1'b1;
                w_upd_en = 1'b1;
            end
            DRAIN: begin
                busy     = 1'b1;
                w_upd_en = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Counter only advances while staying in RUN, so it never wraps into a second pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_first <= 1'b0;
        end else if (w_start_ok) begin
            r_cnt   <= '0;
            r_first <= first_hit;
        end else if ((r_state == RUN) && (w_state_nxt == RUN)) begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    knap_best_track #(
        .N_ITEMS (N_ITEMS),
        .VAL_W   (VAL_W)
    ) u_best (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (w_start_ok),
        .i_cap_en      (w_cap_en),
        .i_upd_en      (w_upd_en),
        .i_cand        (cand),
        .i_valid       (chk_valid),
        .i_value       (chk_value),
        .o_stage_valid (w_stage_valid),
        .o_found       (found),
        .o_best_sel    (best_sel),
        .o_best_value  (best_value)
    );

`ifdef KNAP_STATS_EN
    localparam logic [N_ITEMS:0] NV_MAX = {1'b1, {N_ITEMS{1'b0}}};
    logic [N_ITEMS:0] r_n_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                               r_n_valid <= '0;
        else if (w_start_ok)                                      r_n_valid <= '0;
        else if (w_upd_en && w_stage_valid && (r_n_valid != NV_MAX)) r_n_valid <= r_n_valid + 1'b1;
    end

    assign n_valid = r_n_valid;
`endif

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Directed bench for knap_search_ctrl with N_ITEMS=4 and a behavioural checker model.
module tb_knap_search_ctrl;

    localparam int N = 4;
    localparam int V = 9;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         first_hit;
    logic         abort;
    logic [N-1:0] cand;
    logic         chk_valid;
    logic [V-1:0] chk_value;
    logic         busy;
    logic         done;
    logic         found;
    logic [N-1:0] best_sel;
    logic [V-1:0] best_value;
`ifdef KNAP_STATS_EN
    logic [N:0]   n_valid;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int mode     = 0;

    knap_search_ctrl #(.N_ITEMS(N), .VAL_W(V)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_hit  (first_hit),
        .abort      (abort),
        .cand       (cand),
        .chk_valid  (chk_valid),
        .chk_value  (chk_value),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .best_sel   (best_sel),
        .best_value (best_value)
`ifdef KNAP_STATS_EN
        ,
        .n_valid    (n_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: popcount==2, value=cand; mode 1: never valid; mode 2: valid at 5 and 9, value 5
    always_comb begin
        chk_valid = 1'b0;
        chk_value = '0;
        case (mode)
            0: begin
                chk_valid = ($countones(cand) == 2);
                chk_value = {5'b0, cand};
            end
            1: chk_value = {5'b0, cand};
            2: begin
                chk_valid = (cand == 4'd5) || (cand == 4'd9);
                chk_value = 9'd5;
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start on edge 0, then sample each cycle at the falling edge; inputs change there too.
    task automatic do_search(input logic fh, input int max_cyc, input int abort_cyc,
                             input int dup_cyc, output int done_cyc, output int busy_cnt,
                             output logic [N-1:0] cand1, output logic [N-1:0] cand5,
                             output logic [N-1:0] cand_done);
        @(negedge clk);
        start = 1'b1;
        first_hit = fh;
        @(posedge clk);
        #1;
        start = 1'b0;
        first_hit = 1'b0;
        done_cyc = -1;
        busy_cnt = 0;
        cand1 = '1;
        cand5 = '1;
        cand_done = '1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (c == 1) cand1 = cand;
            if (c == 5) cand5 = cand;
            if (busy) busy_cnt++;
            abort = (c == abort_cyc);
            start = (c == dup_cyc);
            first_hit = (c == dup_cyc);
            if (done) begin
                done_cyc = c;
                cand_done = cand;
                break;
            end
        end
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        first_hit = 1'b0;
    endtask

    int           dc;
    int           bc;
    logic [N-1:0] c1;
    logic [N-1:0] c5;
    logic [N-1:0] cd;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        first_hit = 1'b0;
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_cand", cand, 0);
        chk("rst_best_sel", best_sel, 0);
        chk("rst_best_value", best_value, 0);
`ifdef KNAP_STATS_EN
        chk("rst_n_valid", n_valid, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Full sweep, with a start pulse while busy that must be ignored
        mode = 0;
        do_search(1'b0, 30, 0, 10, dc, bc, c1, c5, cd);
        chk("sweep_done_cyc", dc, 18);
        chk("sweep_busy_cnt", bc, 17);
        chk("sweep_cand_c1", c1, 0);
        chk("sweep_cand_c5", c5, 4);
        chk("sweep_cand_done", cd, 0);
        chk("sweep_found", found, 1);
        chk("sweep_best_sel", best_sel, 4'b1100);
        chk("sweep_best_value", best_value, 12);
        @(negedge clk);
        chk("sweep_done_low", done, 0);
        chk("sweep_idle_busy", busy, 0);
        chk("sweep_hold_sel", best_sel, 4'b1100);
`ifdef KNAP_STATS_EN
        chk("sweep_n_valid", n_valid, 6);
`endif

        // First-hit mode, with start held in the DONE cycle (must be ignored)
        do_search(1'b1, 30, 0, 6, dc, bc, c1, c5, cd);
        chk("fh_done_cyc", dc, 6);
        chk("fh_busy_cnt", bc, 5);
        chk("fh_cand_c5", c5, 4);
        chk("fh_cand_done", cd, 0);
        chk("fh_found", found, 1);
        chk("fh_best_sel", best_sel, 4'b0011);
        chk("fh_best_value", best_value, 3);
        @(negedge clk);
        chk("fh_start_in_done_busy", busy, 0);
`ifdef KNAP_STATS_EN
        chk("fh_n_valid", n_valid, 1);
`endif

        // No valid candidate at all
        mode = 1;
        do_search(1'b0, 30, 0, 0, dc, bc, c1, c5, cd);
        chk("none_done_cyc", dc, 18);
        chk("none_found", found, 0);
        chk("none_best_sel", best_sel, 0);
        chk("none_best_value", best_value, 0);

        // Equal values: the lower-index selection must stay
        mode = 2;
        do_search(1'b0, 30, 0, 0, dc, bc, c1, c5, cd);
        chk("tie_done_cyc", dc, 18);
        chk("tie_found", found, 1);
        chk("tie_best_sel", best_sel, 5);
        chk("tie_best_value", best_value, 5);
`ifdef KNAP_STATS_EN
        chk("tie_n_valid", n_valid, 2);
`endif

        // Abort in cycle 7: busy through cycle 7 only, no done
        mode = 0;
        do_search(1'b0, 14, 7, 0, dc, bc, c1, c5, cd);
        chk("abort_no_done", dc, -1);
        chk("abort_busy_cnt", bc, 7);
        chk("abort_busy_after", busy, 0);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);

        // Restart after abort gives the full-sweep result
        do_search(1'b0, 30, 0, 0, dc, bc, c1, c5, cd);
        chk("restart_done_cyc", dc, 18);
        chk("restart_best_sel", best_sel, 4'b1100);
        chk("restart_best_value", best_value, 12);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_found", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_cand", cand, 0);
        chk("midrst_found", found, 0);
        chk("midrst_best_sel", best_sel, 0);
        chk("midrst_best_value", best_value, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/knap_search_ctrl.md
Name: knap_search_ctrl

Overview:
- Exhaustive-search sequencer for the combinational knapsack validity checkers (one checker per problem instance, one select bit per item).
- Walks every item-selection vector through an externally instantiated checker, one candidate per cycle.
- Registers the checker verdict and keeps the highest-value valid selection.
- Offers a first-hit mode that stops at the first valid selection. Sits between the top-level host/test harness and a checker instance.

Parameters:
- N_ITEMS, 17, number of items; width of the candidate select vector.
- VAL_W, 9, width of the total-value bus returned by the checker.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a search; sampled only in IDLE.
- first_hit  input  1  latched at start: 1 = stop at first valid candidate, 0 = full sweep for maximum value.
- abort  input  1  synchronous abort to IDLE, no done pulse.
- cand  output  N_ITEMS  candidate select vector to checker (bit i = item i).
- chk_valid  input  1  checker verdict for cand, same cycle (combinational).
- chk_value  input  VAL_W  checker total value for cand, same cycle.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  one-cycle pulse at search end.
- found  output  1  at least one valid candidate seen in current/last search.
- best_sel  output  N_ITEMS  best valid selection.
- best_value  output  VAL_W  value of best_sel.

Behaviour:
- Reset (async, rst_n=0): state IDLE; cand, best_sel, best_value, counter, stage regs = 0; busy, done, found = 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start=1, clear counter, found, best_sel, best_value and stage valid; latch first_hit; go to RUN.
  - RUN: cand = counter. Each cycle, stage register captures {cand, chk_valid, chk_value}; counter increments. At counter = 2^N_ITEMS−1, go to DRAIN (counter does not wrap into a new pass).
  - DRAIN: one cycle; processes the final staged result.
  - DONE: done=1 for exactly one cycle, then IDLE. Results hold until the next accepted start.
- Best update, from the stage register, in RUN/DRAIN: if staged valid and (found=0 or staged value > best_value), load best_sel/best_value and set found. Comparison is strict and unsigned, so the lowest-index selection wins ties.
- First-hit mode: the first staged valid result is loaded, then the next state is DONE, bypassing DRAIN. The counter stops.
- Latency:
  - start sampled on edge 0 → cand=0 during cycle 1.
  - Full sweep: done high in cycle 2^N_ITEMS+2.
  - First hit on candidate k: done high in cycle k+3.
- start while busy, or in DONE: ignored. abort and start in the same cycle in IDLE: abort wins, start ignored.
- abort in RUN/DRAIN: next state IDLE; busy drops, no done. found/best_* keep partial results, but are undefined for reporting; a bench must not check them.
- Reset mid-search: immediate return to reset values.
- cand = 0 in IDLE/DONE.

Optional Feature:
- KNAP_STATS_EN defined:
  - Adds output n_valid, width N_ITEMS+1, counting staged valid candidates in the current search.
  - Cleared at start; saturates at 2^N_ITEMS; holds after done.
- Not defined: port and counter absent; all other behaviour identical.

Decomposition:
- Package knap_pkg: state enum (IDLE, RUN, DRAIN, DONE) and default N_ITEMS/VAL_W constants.
- One natural sub-module, knap_best_track: stage register plus best/found compare-and-update, parameterised on N_ITEMS/VAL_W.
- FSM and counter stay in the top.

Test Plan (N_ITEMS=4, VAL_W=9; behavioural checker model: valid iff popcount(cand)==2, value = cand):
- Full sweep: start=1, first_hit=0 → busy cycles 1–17; done in cycle 18; best_sel=4'b1100, best_value=12, found=1.
- First hit: first_hit=1 → done in cycle 6 (k=3); best_sel=4'b0011, best_value=3; cand stops advancing.
- No solution: model valid never asserted → done in cycle 18, found=0, best_sel=0, best_value=0.
- Ties: model value constant 5, valid for cand ∈ {5,9} → best_sel=5, best_value=5.
- Abort/reset: abort in cycle 7 → IDLE, busy=0, no done; new start then gives the full-sweep result. rst_n low mid-RUN → all outputs 0 asynchronously.
- KNAP_STATS_EN: full sweep with the popcount model → n_valid=6; start while busy ignored (result unchanged).
